usb_nrzi_tx: RTL and testbench
==============================

# usb_nrzi_tx

Transmit line encoder sitting directly downstream of the USB bit stuffer. It consumes the stuffed serial bitstream (one bit per clock, qualified by a valid), prefixes each packet with a SYNC pattern, NRZI-encodes the data onto the D+/D- line pair, and closes the packet with an EOP (SE0 then J). Its outputs drive the transceiver pads and output-enable; the clock is the bit clock.

## Interface
- SYNC_LEN, 8: SYNC length in bit times: (SYNC_LEN-1) zeros then one 1, NRZI-encoded; legal range 2..32.
- EOP_SE0_CYCLES, 2: number of SE0 bit times in EOP; legal range 1..4.
- clk  in  1  bit clock; all state updates on rising edge.
- nRST  in  1  asynchronous, active-low reset.
- tx_start  in  1  packet start request; sampled only in IDLE.
- in_bit  in  1  stuffed data bit.
- in_valid  in  1  in_bit is a real bit this cycle; low means no bit this cycle (line holds).
- tx_eop  in  1  end-of-packet request; sampled in SYNC and DATA.
- in_ready  out  1  block accepts in_bit/in_valid this cycle.
- dp  out  1  D+ line level (registered).
- dm  out  1  D- line level (registered).
- oe  out  1  pad output enable (registered).
- busy  out  1  high whenever state is not IDLE.

## Operation
- Line symbols: J = dp 1 / dm 0; K = dp 0 / dm 1; SE0 = dp 0 / dm 0.
- NRZI: bit 0 toggles J<->K; bit 1 holds the current symbol.
- States: IDLE, SYNC, DATA, EOP_SE0, EOP_J.
- IDLE: dp=1, dm=0, oe=0; NRZI reference level = J. tx_start=1 -> SYNC.
- SYNC: emits SYNC_LEN symbols from reference J; default sequence K J K J K J K K. A counter of $clog2(SYNC_LEN+1) bits counts emitted symbols; after the last, -> DATA. The line level after SYNC is the NRZI reference for DATA.
- DATA: in_ready = 1 unless eop_pending. Each edge with in_valid=1 and in_ready=1 encodes in_bit. in_valid=0 holds the line. No bit stuffing is done here; the input is already stuffed.
- tx_eop while in SYNC: sets eop_pending. SYNC still completes, then -> EOP_SE0 with no DATA bits.
- tx_eop while in DATA: if in_valid is also high, that bit is encoded at the same edge. eop_pending is set, and the next edge enters EOP_SE0 regardless of in_valid.
- EOP_SE0: SE0 for EOP_SE0_CYCLES cycles (oe=1), then -> EOP_J.
- EOP_J: J for 1 cycle (oe=1), then -> IDLE, where oe drops to 0, line stays J, and eop_pending clears.
- Ignored inputs:
  - tx_start outside IDLE.
  - tx_eop in IDLE, EOP_SE0, EOP_J.
  - in_valid outside DATA (in_ready=0).

## Timing
- Reset (async assert): dp=1, dm=0, oe=0, busy=0, in_ready=0, state=IDLE, counters=0, eop_pending=0. Applies immediately, including mid-packet; there is no partial EOP.
- Reset release: first action is on the first rising edge with nRST high.
- Packet start:
  - Edge N samples tx_start: after edge N, oe=1 and the first K is on the line. busy rises after edge N.
  - After edge N+SYNC_LEN, state is DATA; in_ready is high combinationally from state.
- Data latency: the bit accepted at edge M appears on dp/dm after edge M (one register stage).
- EOP timing: tx_eop sampled at edge E in DATA:
  - SE0 occupies the cycles after edges E+1 .. E+EOP_SE0_CYCLES.
  - J follows after edge E+EOP_SE0_CYCLES+1.
  - IDLE (oe=0) after edge E+EOP_SE0_CYCLES+2.
- Back-to-back packets: tx_start in the first IDLE cycle starts a new SYNC at the next edge. Minimum inter-packet gap is 1 idle cycle.
- busy falls after the edge that leaves EOP_J.

## Test plan
- Reset mid-DATA with line at K, oe=1 -> dp=1, dm=0, oe=0, busy=0 immediately, without waiting for a clock edge.
- tx_start pulse, defaults -> 8 cycles K J K J K J K K with oe=1, then in_ready=1.
- After SYNC, in_bit sequence 1,0,1,0,0,1,0,1 (0xA5 LSB-first), in_valid=1 -> line K,J,J,K,J,J,K,K.
- in_valid held 0 for 3 cycles mid-DATA -> line level unchanged for those 3 cycles, no bit lost, next bit encoded correctly.
- tx_eop with in_valid=1 and in_bit=0 on the same edge, line at K -> J for 1 cycle, SE0 for 2 cycles, J for 1 cycle, then oe=0; in_ready low from the next cycle.
- tx_eop during SYNC, plus tx_start pulses while busy -> full 8-symbol SYNC, then EOP, no DATA bits accepted, extra tx_start ignored; SYNC_LEN=32 variant emits 31 alternating symbols then a final K.

Source files
------------

// File: rtl/usb_nrzi_tx_if.sv
// Handshake and line-pad bundle between the bit stuffer, the NRZI line encoder and the pads.
interface usb_nrzi_tx_if;
  logic tx_start;
  logic in_bit;
  logic in_valid;
  logic tx_eop;
  logic in_ready;
  logic dp;
  logic dm;
  logic oe;
  logic busy;

  modport master (
    output tx_start, in_bit, in_valid, tx_eop,
    input  in_ready, dp, dm, oe, busy
  );

  modport slave (
    input  tx_start, in_bit, in_valid, tx_eop,
    output in_ready, dp, dm, oe, busy
  );
endinterface

// File: rtl/usb_nrzi_tx.sv
// USB transmit line encoder: SYNC preamble, NRZI encoding of the stuffed bitstream, EOP (SE0 then J).
module usb_nrzi_tx #(
  parameter int unsigned SYNC_LEN       = 8,
  parameter int unsigned EOP_SE0_CYCLES = 2
) (
  input logic          clk,
  input logic          nRST,
  usb_nrzi_tx_if.slave bus
);

  localparam int unsigned SYNC_W = $clog2(SYNC_LEN + 1);
  localparam int unsigned EOP_W  = $clog2(EOP_SE0_CYCLES + 1);
  localparam int unsigned CNT_W  = (SYNC_W > EOP_W) ? SYNC_W : EOP_W;

  typedef enum logic [2:0] {
    IDLE,
    SYNC,
    DATA,
    EOP_SE0,
    EOP_J
  } state_t;

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic             eop_pending;
  logic             dp_q;
  logic             dm_q;
  logic             oe_q;

  assign bus.dp       = dp_q;
  assign bus.dm       = dm_q;
  assign bus.oe       = oe_q;
  assign bus.busy     = (state != IDLE);
  assign bus.in_ready = (state == DATA) && !eop_pending;

  // Line is always J or K outside EOP_SE0, so an NRZI toggle is dp <= ~dp, dm <= dp.
  always_ff @(posedge clk or negedge nRST) begin
    if (!nRST) begin
      state       <= IDLE;
      cnt         <= '0;
      eop_pending <= 1'b0;
      dp_q        <= 1'b1;
      dm_q        <= 1'b0;
      oe_q        <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.tx_start) begin
            state <= SYNC;
            cnt   <= CNT_W'(1);
            dp_q  <= 1'b0;
            dm_q  <= 1'b1;
            oe_q  <= 1'b1;
          end
        end

        SYNC: begin
          if (bus.tx_eop) eop_pending <= 1'b1;
          if (cnt == CNT_W'(SYNC_LEN)) begin
            if (eop_pending || bus.tx_eop) begin
              state <= EOP_SE0;
              cnt   <= CNT_W'(1);
              dp_q  <= 1'b0;
              dm_q  <= 1'b0;
            end else begin
              state <= DATA;
              cnt   <= '0;
            end
          end else begin
            cnt <= cnt + CNT_W'(1);
            // Last SYNC symbol encodes a 1, so the line holds.
            if (cnt != CNT_W'(SYNC_LEN - 1)) begin
              dp_q <= ~dp_q;
              dm_q <= dp_q;
            end
          end
        end

        DATA: begin
          if (eop_pending) begin
            state <= EOP_SE0;
            cnt   <= CNT_W'(1);
            dp_q  <= 1'b0;
            dm_q  <= 1'b0;
          end else begin
            if (bus.in_valid && !bus.in_bit) begin
              dp_q <= ~dp_q;
              dm_q <= dp_q;
            end
            if (bus.tx_eop) eop_pending <= 1'b1;
          end
        end

        EOP_SE0: begin
          if (cnt == CNT_W'(EOP_SE0_CYCLES)) begin
            state <= EOP_J;
            cnt   <= '0;
            dp_q  <= 1'b1;
            dm_q  <= 1'b0;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end

        EOP_J: begin
          state       <= IDLE;
          oe_q        <= 1'b0;
          eop_pending <= 1'b0;
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_usb_nrzi_tx.sv
// Self-checking bench for usb_nrzi_tx: directed line-sequence checks plus randomized traffic against a symbol-queue model.
module tb_usb_nrzi_tx;

  localparam int SL = 8;
  localparam int EC = 2;
  localparam bit [1:0] J   = 2'b10;
  localparam bit [1:0] K   = 2'b01;
  localparam bit [1:0] SE0 = 2'b00;

  bit clk  = 1'b0;
  bit nrst = 1'b0;
  bit cmp_en = 1'b0;
  int n_chk  = 0;
  int n_pass = 0;

  always #5 clk = ~clk;

  usb_nrzi_tx_if a_if ();
  usb_nrzi_tx_if b_if ();

  usb_nrzi_tx dut_a (
    .clk  (clk),
    .nRST (nrst),
    .bus  (a_if.slave)
  );

  usb_nrzi_tx #(.SYNC_LEN(32), .EOP_SE0_CYCLES(2)) dut_b (
    .clk  (clk),
    .nRST (nrst),
    .bus  (b_if.slave)
  );

  task automatic chk(input string name, input int got, input int exp);
    n_chk++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d at %0t", name, got, exp, $time);
  endtask

  task automatic step();
    @(posedge clk);
    #3;
  endtask

  // Model: packet symbols are queued ahead of time; data bits flip the level on a 0.
  bit       m_pkt   = 1'b0;
  bit       m_data  = 1'b0;
  bit       m_trail = 1'b0;
  bit       m_eop   = 1'b0;
  bit       m_oe    = 1'b0;
  bit [1:0] m_line  = J;
  bit [1:0] m_lv    = J;
  bit [1:0] m_q[$];

  always @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      m_pkt = 0; m_data = 0; m_trail = 0; m_eop = 0; m_oe = 0; m_line = J;
      m_q.delete();
    end else if (!m_pkt) begin
      if (a_if.tx_start) begin
        m_pkt = 1; m_oe = 1; m_lv = J;
        for (int i = 0; i < SL; i++) begin
          if (i != SL - 1) m_lv = (m_lv == J) ? K : J;
          m_q.push_back(m_lv);
        end
        m_line = m_q.pop_front();
      end
    end else if (m_q.size() > 0) begin
      if (!m_trail && a_if.tx_eop) m_eop = 1;
      m_line = m_q.pop_front();
    end else if (m_trail) begin
      m_pkt = 0; m_trail = 0; m_eop = 0; m_oe = 0; m_line = J;
    end else if (!m_data && !(m_eop || a_if.tx_eop)) begin
      m_data = 1;
    end else if (!m_data || m_eop) begin
      m_data = 0; m_trail = 1;
      for (int i = 0; i < EC; i++) m_q.push_back(SE0);
      m_q.push_back(J);
      m_line = m_q.pop_front();
    end else begin
      if (a_if.in_valid && !a_if.in_bit) m_line = (m_line == J) ? K : J;
      if (a_if.tx_eop) m_eop = 1;
    end
  end

  always @(negedge clk) begin
    if (cmp_en) begin
      chk("model_line",  int'({a_if.dp, a_if.dm}), int'(m_line));
      chk("model_oe",    int'(a_if.oe), int'(m_oe));
      chk("model_busy",  int'(a_if.busy), int'(m_pkt));
      chk("model_ready", int'(a_if.in_ready), int'(m_pkt && m_data && !m_eop));
    end
  end

  task automatic chk_a(input string name, input bit [1:0] line, input bit oe, input bit busy, input bit rdy);
    chk({name, "_line"},  int'({a_if.dp, a_if.dm}), int'(line));
    chk({name, "_oe"},    int'(a_if.oe), int'(oe));
    chk({name, "_busy"},  int'(a_if.busy), int'(busy));
    chk({name, "_ready"}, int'(a_if.in_ready), int'(rdy));
  endtask

  bit [1:0] sync8[8]  = '{K, J, K, J, K, J, K, K};
  bit [1:0] data8[8]  = '{K, J, J, K, J, J, K, K};
  bit [7:0] a5        = 8'hA5;
  bit [1:0] exp_b;

  initial begin
    {a_if.tx_start, a_if.in_bit, a_if.in_valid, a_if.tx_eop} = '0;
    {b_if.tx_start, b_if.in_bit, b_if.in_valid, b_if.tx_eop} = '0;
    repeat (2) step();
    chk_a("reset_a", J, 0, 0, 0);
    chk("reset_b_line", int'({b_if.dp, b_if.dm}), int'(J));
    chk("reset_b_oe", int'(b_if.oe), 0);
    nrst = 1'b1;
    cmp_en = 1'b1;
    step();
    chk_a("idle_a", J, 0, 0, 0);

    // Default SYNC followed by 0xA5, LSB first.
    a_if.tx_start = 1;
    for (int i = 0; i < SL; i++) begin
      step();
      a_if.tx_start = 0;
      chk_a("sync", sync8[i], 1, 1, 0);
    end
    step();
    chk_a("data_entry", K, 1, 1, 1);
    for (int i = 0; i < 8; i++) begin
      a_if.in_valid = 1; a_if.in_bit = a5[i];
      step();
      chk_a("data_a5", data8[i], 1, 1, 1);
    end
    a_if.in_valid = 0;
    for (int i = 0; i < 3; i++) begin
      a_if.in_bit = 1'($urandom);
      step();
      chk_a("hold", K, 1, 1, 1);
    end
    a_if.in_valid = 1; a_if.in_bit = 0;
    step();
    chk_a("after_hold", J, 1, 1, 1);
    step();
    chk_a("to_k", K, 1, 1, 1);
    a_if.tx_eop = 1;
    step();
    a_if.tx_eop = 0; a_if.in_valid = 0;
    chk_a("eop_bit", J, 1, 1, 0);
    step(); chk_a("eop_se0_1", SE0, 1, 1, 0);
    step(); chk_a("eop_se0_2", SE0, 1, 1, 0);
    step(); chk_a("eop_j", J, 1, 1, 0);
    step(); chk_a("eop_idle", J, 0, 0, 0);

    // Back-to-back packet: EOP during SYNC, extra tx_start while busy.
    a_if.tx_start = 1;
    for (int i = 0; i < SL; i++) begin
      step();
      chk_a("sync_eop", sync8[i], 1, 1, 0);
      a_if.tx_start = (i % 2 == 0) && (i < SL - 2);
      a_if.tx_eop = (i == 2);
    end
    a_if.tx_start = 0; a_if.tx_eop = 0;
    a_if.in_valid = 1;
    step(); chk_a("sync_eop_se0_1", SE0, 1, 1, 0);
    step(); chk_a("sync_eop_se0_2", SE0, 1, 1, 0);
    step(); chk_a("sync_eop_j", J, 1, 1, 0);
    a_if.in_valid = 0;
    step(); chk_a("sync_eop_idle", J, 0, 0, 0);
    step(); chk_a("stays_idle", J, 0, 0, 0);

    // 32-symbol SYNC on the second instance.
    b_if.tx_start = 1;
    for (int i = 0; i < 32; i++) begin
      step();
      b_if.tx_start = 0;
      exp_b = (i == 31 || i % 2 == 0) ? K : J;
      chk("sync32_line", int'({b_if.dp, b_if.dm}), int'(exp_b));
      chk("sync32_ready", int'(b_if.in_ready), 0);
    end
    step();
    chk("sync32_data_ready", int'(b_if.in_ready), 1);
    b_if.tx_eop = 1;
    step();
    b_if.tx_eop = 0;
    step();
    chk("sync32_se0", int'({b_if.dp, b_if.dm}), int'(SE0));
    repeat (3) step();
    chk("sync32_idle_oe", int'(b_if.oe), 0);
    chk("sync32_idle_busy", int'(b_if.busy), 0);

    // Asynchronous reset while in DATA with the line at K.
    a_if.tx_start = 1;
    step();
    a_if.tx_start = 0;
    repeat (SL) step();
    chk_a("pre_reset", K, 1, 1, 1);
    nrst = 0;
    #1;
    chk_a("async_reset", J, 0, 0, 0);
    step();
    nrst = 1;
    step();

    // Randomized traffic against the model.
    for (int c = 0; c < 4000; c++) begin
      a_if.tx_start = ($urandom % 6) == 0;
      a_if.in_valid = ($urandom % 4) != 0;
      a_if.in_bit   = 1'($urandom);
      a_if.tx_eop   = ($urandom % 24) == 0;
      nrst          = ($urandom % 1500) != 0;
      step();
    end
    nrst = 1;
    repeat (2) step();
    cmp_en = 0;

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
